// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: default word width, bit-order selectors
// and the bit-counter width helper used by both ends of the link.
package serial_link_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam bit MSB_FIRST_IDX0 = 1'b0;
  localparam bit LSB_FIRST      = 1'b1;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : unsigned'($clog2(w));
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-MODULUS bit counter with enable and synchronous restart; flags the final bit of a word.
module sipo_bit_counter
  import serial_link_pkg::*;
#(
  parameter int unsigned MODULUS = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic wrap_c
);

  localparam int unsigned CW = cnt_width(MODULUS);
  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  // Restart wins over a sample, so it also suppresses completion.
  assign wrap_c = en & ~restart & (count == LAST);

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial-to-parallel word receiver: reassembles WIDTH-bit words from a qualified serial
// stream into a one-word holding register with valid/ready handoff and sticky overrun.
module sipo_word_receiver #(
  parameter int unsigned WIDTH     = serial_link_pkg::DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = serial_link_pkg::MSB_FIRST_IDX0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift,
  input  logic             serial_in,
  input  logic             restart,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [0:WIDTH-1] data_out,
  output logic             out_valid,
  output logic             overrun
);

  import serial_link_pkg::*;

  if (WIDTH < 2) begin : g_width_check
    $error("sipo_word_receiver: WIDTH must be at least 2");
  end

  logic [0:WIDTH-1] sr;
  logic [0:WIDTH-1] word_c;
  logic             wrap_c;
  logic             load_c;
  logic             drop_c;

  sipo_bit_counter #(
    .MODULUS (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (clear),
    .en      (shift),
    .restart (restart),
    .wrap_c  (wrap_c)
  );

  // Partial word shifted by one with the current bit; on wrap this is the full word.
  always_comb begin
    word_c = '0;
    if (LSB_FIRST) begin
      word_c = {serial_in, sr[0:WIDTH-2]};
    end else begin
      word_c = {sr[1:WIDTH-1], serial_in};
    end
  end

  assign load_c = wrap_c & (~out_valid | out_ready);
  assign drop_c = wrap_c & out_valid & ~out_ready;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sr <= '0;
    end else if (restart || wrap_c) begin
      sr <= '0;
    end else if (shift) begin
      sr <= word_c;
    end
  end

  // Holding register: a same-edge consume frees the slot for the incoming word.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (load_c) begin
      data_out  <= word_c;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A drop on the same edge as ovr_clr keeps the flag set.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      overrun <= 1'b0;
    end else if (drop_c) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Directed bench for sipo_word_receiver (WIDTH=4, first serial bit -> data_out[0]).
module tb_sipo_word_receiver;

  logic       clk;
  logic       clear;
  logic       shift;
  logic       serial_in;
  logic       restart;
  logic       out_ready;
  logic       ovr_clr;
  logic [0:3] data_out;
  logic       out_valid;
  logic       overrun;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       sh;
    logic       si;
    logic       rs;
    logic       rdy;
    logic       oc;
    logic [3:0] d;
    logic       v;
    logic       o;
  } vec_t;

  vec_t vecs[$];

  sipo_word_receiver #(
    .WIDTH     (4),
    .LSB_FIRST (1'b0)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .shift     (shift),
    .serial_in (serial_in),
    .restart   (restart),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .data_out  (data_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic sh, input logic si, input logic rs, input logic rdy,
                              input logic oc, input logic [3:0] d, input logic v, input logic o);
    vec_t r;
    r.sh = sh; r.si = si; r.rs = rs; r.rdy = rdy; r.oc = oc;
    r.d = d; r.v = v; r.o = o;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] d, input logic v, input logic o);
    logic [3:0] dw;
    dw = data_out;
    chk({nm, ".data"},    8'(dw),        8'(d));
    chk({nm, ".valid"},   8'(out_valid), 8'(v));
    chk({nm, ".overrun"}, 8'(overrun),   8'(o));
  endtask

  task automatic drive(input logic sh, input logic si, input logic rs, input logic rdy, input logic oc);
    shift = sh; serial_in = si; restart = rs; out_ready = rdy; ovr_clr = oc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Single word 1,1,1,0 with consumer ready
    vecs.push_back(mk(1,1,0,1,0, 4'b0000,0,0));
    vecs.push_back(mk(1,1,0,1,0, 4'b0000,0,0));
    vecs.push_back(mk(1,1,0,1,0, 4'b0000,0,0));
    vecs.push_back(mk(1,0,0,1,0, 4'b1110,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'b1110,0,0));
    vecs.push_back(mk(0,0,0,1,0, 4'b1110,0,0));
    // Back-to-back 1110 then 0110, consumer stalled: second word dropped
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b1110,1,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b1110,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,1,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b1110,1,1));
    vecs.push_back(mk(0,0,0,0,0, 4'b1110,1,1));
    vecs.push_back(mk(0,0,0,0,1, 4'b1110,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'b1110,0,0));
    // Consume on the same edge the second word completes
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,0,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b1110,1,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b1110,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1110,1,0));
    vecs.push_back(mk(1,0,0,1,0, 4'b0110,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'b0110,0,0));
    // Word 1000 held, then a drop coinciding with ovr_clr: set wins
    vecs.push_back(mk(1,1,0,0,0, 4'b0110,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b0110,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b0110,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b1000,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1000,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1000,1,0));
    vecs.push_back(mk(1,1,0,0,0, 4'b1000,1,0));
    vecs.push_back(mk(1,1,0,0,1, 4'b1000,1,1));
    vecs.push_back(mk(0,0,0,0,1, 4'b1000,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'b1000,0,0));
    vecs.push_back(mk(0,1,0,1,0, 4'b1000,0,0));

    // Reset held from t=0, released at 6ns
    #2;
    chk_all("reset_held", 4'b0000, 0, 0);
    #4;
    clear = 1'b1;
    step();
    chk_all("reset_idle0", 4'b0000, 0, 0);
    drive(0, 1, 0, 1, 0);
    step();
    chk_all("reset_idle1", 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].sh, vecs[i].si, vecs[i].rs, vecs[i].rdy, vecs[i].oc);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].v, vecs[i].o);
    end

    // Gaps: bits 1,0, three idle cycles with noise on serial_in, then 1,1 -> 1011
    drive(1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0); step();
    for (int g = 0; g < 3; g++) begin
      drive(0, g[0], 0, 0, 0);
      step();
      chk("gap.valid", 8'(out_valid), 8'd0);
    end
    drive(1, 1, 0, 0, 0); step();
    chk("gap.pre_valid", 8'(out_valid), 8'd0);
    drive(1, 1, 0, 0, 0); step();
    chk_all("gap_word", 4'b1011, 1, 0);
    drive(0, 0, 0, 1, 0); step();
    chk("gap.consumed", 8'(out_valid), 8'd0);

    // Restart: two bits, restart with shift high, then 1111
    drive(1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0); step();
    drive(1, 0, 1, 0, 0); step();
    chk("restart.valid0", 8'(out_valid), 8'd0);
    for (int b = 0; b < 3; b++) begin
      drive(1, 1, 0, 0, 0);
      step();
      chk("restart.partial", 8'(out_valid), 8'd0);
    end
    drive(1, 1, 0, 0, 0); step();
    chk_all("restart_word", 4'b1111, 1, 0);

    // Reset mid-word while 1111 is still held
    drive(1, 1, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    #2;
    clear = 1'b0;
    #1;
    chk_all("midreset", 4'b0000, 0, 0);
    #1;
    clear = 1'b1;
    drive(1, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    chk("midreset.no_stale", 8'(out_valid), 8'd0);
    drive(1, 0, 0, 0, 0); step();
    chk_all("midreset_word", 4'b0110, 1, 0);
    drive(0, 0, 0, 1, 0); step();
    chk_all("midreset_consume", 4'b0110, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
